// File: rtl/dlx_pipe_pkg.sv
// Shared types for the DLX pipeline hazard logic: forwarding selects, the
// per-stage writer record and the matching helpers used by the interlock.
package dlx_pipe_pkg;

  localparam int DLX_REG_AW  = 5;
  localparam int MUL_LAT_DEF = 4;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [DLX_REG_AW-1:0] rd;
    logic                  regwr;
    logic                  is_load;
  } stage_rec_t;

  // r0 is hard-wired zero, so it can never be a hazard or a forward source.
  function automatic logic rec_match(input stage_rec_t rec, input logic [DLX_REG_AW-1:0] r);
    return rec.valid && rec.regwr && (rec.rd == r) && (r != '0);
  endfunction

  function automatic fwd_sel_t fwd_pick(input stage_rec_t ex_rec, input stage_rec_t mem_rec,
                                        input logic [DLX_REG_AW-1:0] r);
    if (rec_match(ex_rec, r))  return FWD_EXMEM;
    if (rec_match(mem_rec, r)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/multicycle_ctr.sv
// Occupancy counter for multi-cycle EX operations: busy for LAT-1 cycles
// after start; clear is an asynchronous wipe tied to the core reset.
module multicycle_ctr #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic start,
  output logic busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start && (LAT > 1)) cnt_d = CW'(LAT - 1);
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock and forwarding controller beside DLX decode: tracks EX/MEM/WB
// writers, raises load-use / branch / multiply stalls, registers EX fwd selects.
module hazard_ctrl
  import dlx_pipe_pkg::*;
#(
  parameter int REG_AW  = DLX_REG_AW,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_kill,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwr,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              id_is_branch,
  output logic              stall,
  output logic              bubble_ex,
  output logic              ex_hold,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mul_busy,
  output stage_rec_t        dbg_wb_rec
);

  stage_rec_t ex_q, mem_q, wb_q;
  stage_rec_t ex_d, mem_d, wb_d;
  stage_rec_t id_rec;
  fwd_sel_t   fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  logic [DLX_REG_AW-1:0] rs1, rs2;
  logic haz_rs1, haz_rs2, hazard, issue;

  assign rs1    = DLX_REG_AW'(id_rs1);
  assign rs2    = DLX_REG_AW'(id_rs2);
  assign id_rec = '{valid: 1'b1, rd: DLX_REG_AW'(id_rd), regwr: id_regwr, is_load: id_is_load};

  // Branches resolve in ID, so rs1 also waits on ALU results in EX and loads in MEM.
  assign haz_rs1 = id_rs1_used &
                   ((rec_match(ex_q, rs1) & ex_q.is_load) |
                    (id_is_branch & rec_match(ex_q, rs1)) |
                    (id_is_branch & rec_match(mem_q, rs1) & mem_q.is_load));
  assign haz_rs2 = id_rs2_used & rec_match(ex_q, rs2) & ex_q.is_load;

  assign hazard = id_valid & ~id_kill & (haz_rs1 | haz_rs2);
  assign issue  = id_valid & ~id_kill & ~hazard & ~mul_busy;

  assign stall     = hazard | mul_busy;
  assign bubble_ex = hazard & ~mul_busy;
  assign ex_hold   = mul_busy;

  always_comb begin
    ex_d    = ex_q;
    mem_d   = '0;
    wb_d    = mem_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!mul_busy) begin
      mem_d   = ex_q;
      ex_d    = issue ? id_rec : '0;
      fwd_a_d = issue ? fwd_pick(ex_q, mem_q, rs1) : FWD_RF;
      fwd_b_d = issue ? fwd_pick(ex_q, mem_q, rs2) : FWD_RF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  multicycle_ctr #(.LAT(MUL_LAT)) u_mul_ctr (
    .clk   (clk),
    .clear (reset),
    .start (issue & id_is_mul),
    .busy  (mul_busy)
  );

  assign fwd_a_sel  = fwd_a_q;
  assign fwd_b_sel  = fwd_b_q;
  assign dbg_wb_rec = wb_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs driven on the falling edge, outputs
// checked 1ns later against hand-derived values for each pipeline scenario.
module tb_hazard_ctrl;
  import dlx_pipe_pkg::*;

  logic       clk, reset;
  logic       id_valid, id_kill;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_regwr, id_is_load, id_is_mul, id_is_branch;
  logic       stall, bubble_ex, ex_hold, mul_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  stage_rec_t dbg_wb_rec;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.REG_AW(5), .MUL_LAT(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_kill(id_kill),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwr(id_regwr), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .id_is_branch(id_is_branch), .stall(stall), .bubble_ex(bubble_ex), .ex_hold(ex_hold),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mul_busy(mul_busy), .dbg_wb_rec(dbg_wb_rec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic wr,
                       input logic ld, input logic ml, input logic br);
    id_valid = 1'b1; id_kill = 1'b0;
    id_rd = rd; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_regwr = wr; id_is_load = ld; id_is_mul = ml; id_is_branch = br;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_kill = 1'b0;
    id_rd = '0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_regwr = 1'b0; id_is_load = 1'b0; id_is_mul = 1'b0; id_is_branch = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); nop();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; nop();
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    total++; if (bubble_ex !== 1'b0) begin bad++; $display("FAIL rst_bubble: got %b want 0", bubble_ex); end
    total++; if (ex_hold !== 1'b0 || mul_busy !== 1'b0) begin bad++; $display("FAIL rst_mul: got hold=%b busy=%b want 0 0", ex_hold, mul_busy); end
    total++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin bad++; $display("FAIL rst_fwd: got %0d %0d want 0 0", fwd_a_sel, fwd_b_sel); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_load_use();
    flush();
    @(negedge clk); drive(5'd3, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_lw_stall: got %b want 0", stall); end
    @(negedge clk); drive(5'd4, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (stall !== 1'b1 || bubble_ex !== 1'b1) begin bad++; $display("FAIL lu_stall1: got stall=%b bubble=%b want 1 1", stall, bubble_ex); end
    @(negedge clk);
    #1;
    total++; if (stall !== 1'b0 || bubble_ex !== 1'b0) begin bad++; $display("FAIL lu_stall2: got stall=%b bubble=%b want 0 0", stall, bubble_ex); end
    @(negedge clk); nop();
    #1;
    total++; if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd0) begin bad++; $display("FAIL lu_fwd: got %0d %0d want 2 0", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_alu_b2b();
    flush();
    @(negedge clk); drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(5'd2, 5'd1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b want 0", stall); end
    @(negedge clk); drive(5'd10, 5'd11, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd1) begin bad++; $display("FAIL alu_fwd_sub: got %0d %0d want 1 1", fwd_a_sel, fwd_b_sel); end
    @(negedge clk); drive(5'd6, 5'd1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin bad++; $display("FAIL alu_fwd_ind: got %0d %0d want 0 0", fwd_a_sel, fwd_b_sel); end
    @(negedge clk); nop();
    #1;
    total++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin bad++; $display("FAIL alu_fwd_or: got %0d %0d want 0 0", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_branch();
    int stalls;
    flush();
    @(negedge clk); drive(5'd7, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      #1; if (stall === 1'b1) stalls++;
      @(negedge clk);
    end
    nop();
    total++; if (stalls !== 2) begin bad++; $display("FAIL br_load_stalls: got %0d want 2", stalls); end
    flush();
    @(negedge clk); drive(5'd7, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      #1; if (stall === 1'b1) stalls++;
      @(negedge clk);
    end
    nop();
    total++; if (stalls !== 1) begin bad++; $display("FAIL br_alu_stalls: got %0d want 1", stalls); end
  endtask

  task automatic test_reg0();
    flush();
    @(negedge clk); drive(5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(5'd1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall: got %b want 0", stall); end
    @(negedge clk); nop();
    #1;
    total++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin bad++; $display("FAIL r0_fwd: got %0d %0d want 0 0", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_mul();
    flush();
    @(negedge clk); drive(5'd2, 5'd10, 1'b1, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(5'd8, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    total++; if (mul_busy !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mul_pre: got busy=%b stall=%b want 0 0", mul_busy, stall); end
    @(negedge clk); drive(5'd9, 5'd8, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (mul_busy !== 1'b1 || ex_hold !== 1'b1 || stall !== 1'b1 || bubble_ex !== 1'b0) begin
      bad++; $display("FAIL mul_busy1: got busy=%b hold=%b stall=%b bubble=%b want 1 1 1 0", mul_busy, ex_hold, stall, bubble_ex); end
    total++; if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd0) begin bad++; $display("FAIL mul_own_fwd: got %0d %0d want 1 0", fwd_a_sel, fwd_b_sel); end
    @(negedge clk); #1;
    total++; if (mul_busy !== 1'b1) begin bad++; $display("FAIL mul_busy2: got %b want 1", mul_busy); end
    @(negedge clk); #1;
    total++; if (mul_busy !== 1'b1 || fwd_a_sel !== 2'd1) begin bad++; $display("FAIL mul_busy3: got busy=%b fwd_a=%0d want 1 1", mul_busy, fwd_a_sel); end
    @(negedge clk); #1;
    total++; if (mul_busy !== 1'b0 || ex_hold !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mul_release: got busy=%b hold=%b stall=%b want 0 0 0", mul_busy, ex_hold, stall); end
    @(negedge clk); nop(); #1;
    total++; if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd0) begin bad++; $display("FAIL mul_dep_fwd: got %0d %0d want 1 0", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_mul_branch();
    flush();
    @(negedge clk); drive(5'd8, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk); drive(5'd0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (stall !== 1'b1 || bubble_ex !== 1'b0) begin bad++; $display("FAIL mulbr_busy%0d: got stall=%b bubble=%b want 1 0", i, stall, bubble_ex); end
      @(negedge clk);
    end
    #1;
    total++; if (stall !== 1'b1 || bubble_ex !== 1'b1) begin bad++; $display("FAIL mulbr_release: got stall=%b bubble=%b want 1 1", stall, bubble_ex); end
    @(negedge clk); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mulbr_go: got %b want 0", stall); end
    @(negedge clk); nop();
  endtask

  task automatic test_mul_reset();
    flush();
    @(negedge clk); drive(5'd2, 5'd10, 1'b1, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(5'd8, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk); drive(5'd9, 5'd8, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (mul_busy !== 1'b1 || fwd_a_sel !== 2'd1) begin bad++; $display("FAIL mrst_busy: got busy=%b fwd_a=%0d want 1 1", mul_busy, fwd_a_sel); end
    @(negedge clk); reset = 1'b1; #1;
    total++; if (mul_busy !== 1'b0 || ex_hold !== 1'b0 || stall !== 1'b0 || bubble_ex !== 1'b0) begin
      bad++; $display("FAIL mrst_ctl: got busy=%b hold=%b stall=%b bubble=%b want 0 0 0 0", mul_busy, ex_hold, stall, bubble_ex); end
    total++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0 || dbg_wb_rec.valid !== 1'b0) begin
      bad++; $display("FAIL mrst_state: got fwd=%0d %0d wb_valid=%b want 0 0 0", fwd_a_sel, fwd_b_sel, dbg_wb_rec.valid); end
    @(negedge clk); reset = 1'b0; nop();
  endtask

  task automatic test_kill();
    flush();
    @(negedge clk); drive(5'd3, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(5'd4, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    id_kill = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || bubble_ex !== 1'b0) begin bad++; $display("FAIL kill_stall: got stall=%b bubble=%b want 0 0", stall, bubble_ex); end
    @(negedge clk); drive(5'd6, 5'd4, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL kill_ex_invalid: got stall=%b want 0", stall); end
    @(negedge clk); nop(); #1;
    total++; if (fwd_a_sel !== 2'd0) begin bad++; $display("FAIL kill_fwd: got %0d want 0", fwd_a_sel); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_b2b();
    test_branch();
    test_reg0();
    test_mul();
    test_mul_branch();
    test_mul_reset();
    test_kill();
    flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
